// File: rtl/timer_irq_unit_if.sv
// rtl/timer_irq_unit_if.sv - data-memory bus bundle between the CPU datapath and the interval timer
interface timer_irq_unit_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWr;
    logic        MemRd;
    logic [31:0] ReadData;
    logic        TimerSel;

    modport master (
        output Address,
        output WriteData,
        output MemWr,
        output MemRd,
        input  ReadData,
        input  TimerSel
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWr,
        input  MemRd,
        output ReadData,
        output TimerSel
    );
endinterface

// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - memory-mapped interval timer with reload, prescaler and level IRQ
module timer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    timer_irq_unit_if.slave   bus,
    output logic              IRQ
);
    localparam int unsigned PS_W    = 16;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [31:0] ADDR_TH   = BASE_ADDR;
    localparam logic [31:0] ADDR_TL   = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_TCON = BASE_ADDR + 32'd8;
    localparam logic [31:0] TL_MAX    = 32'hFFFF_FFFF;

    logic [31:0]     th_q, th_d;
    logic [31:0]     tl_q, tl_d;
    logic            en_q, en_d;
    logic            ie_q, ie_d;
    logic            st_q, st_d;
    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;

    logic hit_th, hit_tl, hit_tcon;
    logic wr_th, wr_tl, wr_tcon;
    logic tick;
    logic overflow;

    assign hit_th   = (bus.Address == ADDR_TH);
    assign hit_tl   = (bus.Address == ADDR_TL);
    assign hit_tcon = (bus.Address == ADDR_TCON);

    assign bus.TimerSel = hit_th | hit_tl | hit_tcon;

    assign wr_th   = bus.MemWr & hit_th;
    assign wr_tl   = bus.MemWr & hit_tl;
    assign wr_tcon = bus.MemWr & hit_tcon;

    assign tick = en_q & (ps_cnt_q == PS_LAST);

    // A CPU write to TL swallows the tick, so it can never signal an overflow.
    assign overflow = tick & ~wr_tl & (tl_q == TL_MAX);

    always_comb begin
        ps_cnt_d = ps_cnt_q;
        if (!en_q) begin
            ps_cnt_d = '0;
        end else if (tick) begin
            ps_cnt_d = '0;
        end else begin
            ps_cnt_d = ps_cnt_q + 1'b1;
        end
    end

    always_comb begin
        th_d = th_q;
        tl_d = tl_q;
        en_d = en_q;
        ie_d = ie_q;
        st_d = st_q;

        if (wr_th) begin
            th_d = bus.WriteData;
        end

        // Reload uses the current TH, so a same-cycle TH write only affects later reloads.
        if (wr_tl) begin
            tl_d = bus.WriteData;
        end else if (tick) begin
            if (tl_q == TL_MAX) begin
                tl_d = th_q;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wr_tcon) begin
            en_d = bus.WriteData[0];
            ie_d = bus.WriteData[1];
            if (!bus.WriteData[2]) begin
                st_d = 1'b0;
            end
        end

        // Set after clear so a coincident overflow is never lost.
        if (overflow && ie_q) begin
            st_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q     <= '0;
            tl_q     <= '0;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            st_q     <= 1'b0;
            ps_cnt_q <= '0;
        end else begin
            th_q     <= th_d;
            tl_q     <= tl_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            st_q     <= st_d;
            ps_cnt_q <= ps_cnt_d;
        end
    end

    always_comb begin
        bus.ReadData = 32'h0;
        if (bus.MemRd) begin
            if (hit_th) begin
                bus.ReadData = th_q;
            end else if (hit_tl) begin
                bus.ReadData = tl_q;
            end else if (hit_tcon) begin
                bus.ReadData = {29'd0, st_q, ie_q, en_q};
            end
        end
    end

    assign IRQ = ie_q & st_q;
endmodule

// File: tb/tb_timer_irq_unit.sv
// tb/tb_timer_irq_unit.sv - directed bench for timer_irq_unit with PRESCALE=1 and PRESCALE=4
module tb_timer_irq_unit;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;

    logic clk;
    logic reset;
    logic irq1;
    logic irq4;
    int   total;
    int   bad;
    logic [31:0] rv;

    timer_irq_unit_if bus1();
    timer_irq_unit_if bus4();

    timer_irq_unit #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .IRQ   (irq1)
    );

    timer_irq_unit #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4),
        .IRQ   (irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit sel, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin
            bus4.Address = a; bus4.WriteData = d; bus4.MemWr = 1'b1;
        end else begin
            bus1.Address = a; bus1.WriteData = d; bus1.MemWr = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sel) begin
            bus4.MemWr = 1'b0; bus4.Address = 32'h0; bus4.WriteData = 32'h0;
        end else begin
            bus1.MemWr = 1'b0; bus1.Address = 32'h0; bus1.WriteData = 32'h0;
        end
    endtask

    task automatic rd(input bit sel, input logic [31:0] a, output logic [31:0] d);
        if (sel) begin
            bus4.Address = a; bus4.MemRd = 1'b1;
            #1;
            d = bus4.ReadData;
            bus4.MemRd = 1'b0; bus4.Address = 32'h0;
        end else begin
            bus1.Address = a; bus1.MemRd = 1'b1;
            #1;
            d = bus1.ReadData;
            bus1.MemRd = 1'b0; bus1.Address = 32'h0;
        end
    endtask

    task automatic sel_chk(input string tag, input logic [31:0] a, input logic exp);
        bus1.Address = a;
        #1;
        chk(tag, {31'd0, bus1.TimerSel}, {31'd0, exp});
        bus1.Address = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus1.Address = 32'h0; bus1.WriteData = 32'h0; bus1.MemWr = 1'b0; bus1.MemRd = 1'b0;
        bus4.Address = 32'h0; bus4.WriteData = 32'h0; bus4.MemWr = 1'b0; bus4.MemRd = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_irq1", {31'd0, irq1}, 32'd0);
        chk("rst_irq4", {31'd0, irq4}, 32'd0);
        rd(0, A_TH, rv);   chk("rst_th", rv, 32'h0);
        rd(0, A_TL, rv);   chk("rst_tl", rv, 32'h0);
        rd(0, A_TCON, rv); chk("rst_tcon", rv, 32'h0);
        @(negedge clk);
        sel_chk("sel_th", 32'h4000_0000, 1'b1);
        sel_chk("sel_tl", 32'h4000_0004, 1'b1);
        sel_chk("sel_tcon", 32'h4000_0008, 1'b1);
        sel_chk("sel_0c", 32'h4000_000C, 1'b0);
        @(negedge clk);
        sel_chk("sel_below", 32'h3FFF_FFFC, 1'b0);
        reset = 1'b1;

        // PRESCALE=1 overflow and periodic reload
        wr(0, A_TH, 32'hFFFF_FFFC);
        wr(0, A_TL, 32'hFFFF_FFFE);
        wr(0, A_TCON, 32'h3);
        @(posedge clk); #1;
        rd(0, A_TL, rv); chk("p1_tl_ffff", rv, 32'hFFFF_FFFF);
        chk("p1_irq_pre", {31'd0, irq1}, 32'd0);
        @(posedge clk); #1;
        chk("p1_irq_set", {31'd0, irq1}, 32'd1);
        rd(0, A_TL, rv);   chk("p1_tl_reload", rv, 32'hFFFF_FFFC);
        rd(0, A_TCON, rv); chk("p1_tcon_st", rv, 32'h7);
        repeat (3) @(posedge clk); #1;
        rd(0, A_TL, rv); chk("p1_tl_ffff2", rv, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd(0, A_TL, rv); chk("p1_tl_reload2", rv, 32'hFFFF_FFFC);

        // ST write-0-to-clear
        wr(0, A_TCON, 32'h7);
        chk("st_keep_irq", {31'd0, irq1}, 32'd1);
        wr(0, A_TCON, 32'h3);
        chk("st_clr_irq", {31'd0, irq1}, 32'd0);
        rd(0, A_TL, rv); chk("st_clr_counting", rv, 32'hFFFF_FFFE);
        repeat (2) @(posedge clk); #1;
        chk("reov_irq", {31'd0, irq1}, 32'd1);
        rd(0, A_TL, rv); chk("reov_tl", rv, 32'hFFFF_FFFC);
        repeat (3) @(posedge clk);
        wr(0, A_TCON, 32'h3);
        chk("ov_vs_clr_irq", {31'd0, irq1}, 32'd1);
        rd(0, A_TL, rv); chk("ov_vs_clr_tl", rv, 32'hFFFF_FFFC);

        // TL write beats a tick at TL=FFFF_FFFF
        wr(0, A_TCON, 32'h3);
        chk("clr_again_irq", {31'd0, irq1}, 32'd0);
        wr(0, A_TL, 32'hFFFF_FFFF);
        wr(0, A_TL, 32'h5);
        rd(0, A_TL, rv);   chk("tlwr_tl", rv, 32'h5);
        rd(0, A_TCON, rv); chk("tlwr_tcon", rv, 32'h3);
        chk("tlwr_irq", {31'd0, irq1}, 32'd0);
        @(posedge clk); #1;
        rd(0, A_TL, rv); chk("tlwr_next", rv, 32'h6);

        // TH write during reload: TL gets old TH
        wr(0, A_TL, 32'hFFFF_FFFF);
        wr(0, A_TH, 32'h0000_0100);
        rd(0, A_TL, rv); chk("thwr_tl", rv, 32'hFFFF_FFFC);
        rd(0, A_TH, rv); chk("thwr_th", rv, 32'h0000_0100);
        chk("thwr_irq", {31'd0, irq1}, 32'd1);
        bus1.Address = A_TH; bus1.MemRd = 1'b0;
        #1;
        chk("nord_zero", bus1.ReadData, 32'h0);
        bus1.Address = 32'h0;

        // EN=0 written in a tick cycle
        wr(0, A_TCON, 32'h2);
        rd(0, A_TL, rv); chk("endis_tl", rv, 32'hFFFF_FFFD);
        chk("endis_irq", {31'd0, irq1}, 32'd0);
        @(posedge clk); #1;
        rd(0, A_TL, rv);   chk("endis_hold", rv, 32'hFFFF_FFFD);
        rd(0, A_TCON, rv); chk("endis_tcon", rv, 32'h2);

        // PRESCALE=4 with IE=0, then IE=1
        wr(1, A_TH, 32'h55);
        wr(1, A_TL, 32'hFFFF_FFFF);
        wr(1, A_TCON, 32'h1);
        repeat (3) @(posedge clk); #1;
        rd(1, A_TL, rv); chk("p4_tl_wait", rv, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd(1, A_TL, rv);   chk("p4_reload", rv, 32'h55);
        rd(1, A_TCON, rv); chk("p4_tcon_nost", rv, 32'h1);
        chk("p4_irq_ie0", {31'd0, irq4}, 32'd0);
        wr(1, A_TCON, 32'h3);
        chk("p4_irq_ie1", {31'd0, irq4}, 32'd0);
        rd(1, A_TCON, rv); chk("p4_tcon_ie", rv, 32'h3);
        wr(1, A_TL, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("p4_irq_wait", {31'd0, irq4}, 32'd0);
        rd(1, A_TL, rv); chk("p4_tl_wait2", rv, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("p4_irq_ov", {31'd0, irq4}, 32'd1);
        rd(1, A_TL, rv);   chk("p4_tl_ov", rv, 32'h55);
        rd(1, A_TCON, rv); chk("p4_tcon_ov", rv, 32'h7);
        wr(1, A_TCON, 32'h5);
        chk("mask_irq", {31'd0, irq4}, 32'd0);
        rd(1, A_TCON, rv); chk("mask_tcon", rv, 32'h5);
        wr(1, A_TCON, 32'h7);
        chk("unmask_irq", {31'd0, irq4}, 32'd1);

        // asynchronous reset mid-count
        wr(0, A_TCON, 32'h3);
        repeat (3) @(posedge clk); #1;
        chk("ar_pre_irq", {31'd0, irq1}, 32'd1);
        rd(0, A_TL, rv); chk("ar_pre_tl", rv, 32'h0000_0100);
        reset = 1'b0;
        #1;
        chk("ar_irq1", {31'd0, irq1}, 32'd0);
        chk("ar_irq4", {31'd0, irq4}, 32'd0);
        rd(0, A_TL, rv);   chk("ar_tl1", rv, 32'h0);
        rd(0, A_TCON, rv); chk("ar_tcon1", rv, 32'h0);
        rd(1, A_TL, rv);   chk("ar_tl4", rv, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        rd(0, A_TL, rv);   chk("post_tl", rv, 32'h0);
        rd(0, A_TCON, rv); chk("post_tcon", rv, 32'h0);
        rd(0, A_TH, rv);   chk("post_th", rv, 32'h0);
        chk("post_irq", {31'd0, irq1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
